muldiv_share_ctrl: RTL
======================

Name: muldiv_share_ctrl

Overview:
Sequencing controller and round-robin arbiter that shares one combinational multiplier_divider between two requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The block registers the granted operands onto the datapath and waits a fixed settle time. It then captures Result/Remainder, handles divide-by-zero without using the datapath result, and holds the response until the owning requester accepts it.

Parameters:
DEVIDENT_LENGTH, 10, width of OperA and Result
DIVISOR_LENGTH, 5, width of OperB, OperD and Remainder
SETTLE_CYCLES, 2, clock cycles the datapath is given to settle after operands are registered; legal range 1..15

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ReqN_Valid (N=0,1)  in  1  requester N has an operation pending
ReqN_Ready (N=0,1)  out  1  request N accepted on this edge
ReqN_Div_nMul (N=0,1)  in  1  1 = divide OperA/OperD, 0 = multiply OperB*OperD
ReqN_OperA (N=0,1)  in  DEVIDENT_LENGTH  dividend
ReqN_OperB (N=0,1)  in  DIVISOR_LENGTH  multiplicand
ReqN_OperD (N=0,1)  in  DIVISOR_LENGTH  divisor / multiplier
RspN_Valid (N=0,1)  out  1  response for requester N present
RspN_Ready (N=0,1)  in  1  requester N takes the response
Rsp_Result  out  DEVIDENT_LENGTH  quotient or product (shared)
Rsp_Remainder  out  DIVISOR_LENGTH  remainder; 0 for multiply
Rsp_DivByZero  out  1  divide with OperD==0
MD_OperA, MD_OperB, MD_OperD  out  DEVIDENT_LENGTH / DIVISOR_LENGTH / DIVISOR_LENGTH  registered operands to the datapath
MD_Div_nMul  out  1  registered mode to the datapath
MD_Result  in  DEVIDENT_LENGTH  datapath Result
MD_Remainder  in  DIVISOR_LENGTH  datapath Remainder
Busy  out  1  state != IDLE

Behaviour:
- One clock CLK. Reset nRST is asynchronous and active-low.
- Reset: state=IDLE, all ReqN_Ready/RspN_Valid=0, Rsp_* =0, MD_* =0, Busy=0, round-robin pointer favours requester 0. A reset asserted mid-operation discards the transaction and no response is delivered.

FSM: IDLE, WAIT, RESP.

IDLE:
- Grant logic is combinational from the valids.
- If only one valid, grant it.
- If both are valid, grant the requester favoured by the pointer.
- ReqN_Ready = grantN; it is never high outside IDLE.
- On a handshake at edge k:
  - Load MD_* from the granted requester and record the owner.
  - Point the pointer at the other requester.
  - If Div_nMul=1 and OperD=0: go to RESP with Rsp_Result=all ones, Rsp_Remainder=0, Rsp_DivByZero=1.
  - Otherwise: go to WAIT with counter=SETTLE_CYCLES.

WAIT:
- Counter decrements each edge.
- On the edge where counter==1:
  - Capture Rsp_Result=MD_Result.
  - Capture Rsp_Remainder=MD_Remainder for divide, 0 for multiply.
  - Set Rsp_DivByZero=0 and go to RESP.
- Normal latency: Rsp_Valid is high in the cycle after edge k+SETTLE_CYCLES. For divide-by-zero it is high in the cycle after edge k.

RESP:
- RspOwner_Valid=1; the other RspN_Valid=0.
- Rsp_* stay stable until the owner's RspN_Ready is sampled high; then go to IDLE.
- No new request is accepted on that same edge, so the minimum spacing is one IDLE cycle.

Other rules:
- MD_* hold their last value in all states and change only on request acceptance.
- Arithmetic: the product is the full DIVISOR_LENGTH*2 bits, zero-extended to DEVIDENT_LENGTH. Multiply ignores OperA. The quotient is DEVIDENT_LENGTH bits.
- Ready from the non-owning requester is ignored. ReqN inputs are don't-care unless Valid is high.

Test Plan:
1. Req0 mul B=20 D=25, Rsp0_Ready=1 -> Rsp0_Valid 2 cycles after acceptance, Result=500, Remainder=0, DivByZero=0. MD_Div_nMul=0.
2. Req1 div A=1023 D=15 -> Rsp1_Valid with Result=68, Remainder=3. Req0_Ready stays 0 throughout.
3. Both valid continuously after reset: Req0 mul 4*3, Req1 div 25/7. Grants alternate 0,1,0,1 -> responses 12/0, 3/4, 12/0, 3/4. No response ever appears on the wrong requester.
4. Req0 div A=21 D=0 -> Rsp0_Valid 1 cycle after acceptance, Result=1023, Remainder=0, DivByZero=1. A following div 21/7 returns 3/0 with DivByZero=0.
5. Rsp0_Ready held low 6 cycles with Req1_Valid=1 -> Rsp0_Valid and Rsp_* stable, Busy=1, Req1_Ready=0. Req1 is granted the first IDLE cycle after Rsp0_Ready.
6. nRST pulsed low during WAIT of mul 31*31 -> all outputs 0 immediately with no clock edge, no response issued. After release, Req1-only request 12*15 returns 180.

Source files
------------

// File: rtl/muldiv_share_ctrl.sv
// Round-robin sequencer sharing one combinational multiplier/divider between two requesters.
// Response SETTLE_CYCLES edges after accept (1 edge for divide-by-zero); held until the owner takes it.
module muldiv_share_ctrl #(
   parameter int DEVIDENT_LENGTH = 10,
   parameter int DIVISOR_LENGTH  = 5,
   parameter int SETTLE_CYCLES   = 2
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       Req0_Valid,
   output logic                       Req0_Ready,
   input  logic                       Req0_Div_nMul,
   input  logic [DEVIDENT_LENGTH-1:0] Req0_OperA,
   input  logic [DIVISOR_LENGTH-1:0]  Req0_OperB,
   input  logic [DIVISOR_LENGTH-1:0]  Req0_OperD,
   input  logic                       Req1_Valid,
   output logic                       Req1_Ready,
   input  logic                       Req1_Div_nMul,
   input  logic [DEVIDENT_LENGTH-1:0] Req1_OperA,
   input  logic [DIVISOR_LENGTH-1:0]  Req1_OperB,
   input  logic [DIVISOR_LENGTH-1:0]  Req1_OperD,
   output logic                       Rsp0_Valid,
   input  logic                       Rsp0_Ready,
   output logic                       Rsp1_Valid,
   input  logic                       Rsp1_Ready,
   output logic [DEVIDENT_LENGTH-1:0] Rsp_Result,
   output logic [DIVISOR_LENGTH-1:0]  Rsp_Remainder,
   output logic                       Rsp_DivByZero,
   output logic [DEVIDENT_LENGTH-1:0] MD_OperA,
   output logic [DIVISOR_LENGTH-1:0]  MD_OperB,
   output logic [DIVISOR_LENGTH-1:0]  MD_OperD,
   output logic                       MD_Div_nMul,
   input  logic [DEVIDENT_LENGTH-1:0] MD_Result,
   input  logic [DIVISOR_LENGTH-1:0]  MD_Remainder,
   output logic                       Busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

   state_t                     r_state;
   logic [3:0]                 r_cnt;
   logic                       r_owner;
   logic                       r_rr_ptr;
   logic                       r_rsp0_vld;
   logic                       r_rsp1_vld;
   logic                       r_dbz;
   logic                       r_md_div;
   logic [DEVIDENT_LENGTH-1:0] r_result;
   logic [DEVIDENT_LENGTH-1:0] r_md_a;
   logic [DIVISOR_LENGTH-1:0]  r_rem;
   logic [DIVISOR_LENGTH-1:0]  r_md_b;
   logic [DIVISOR_LENGTH-1:0]  r_md_d;

   logic                       w_idle;
   logic                       w_grant0;
   logic                       w_grant1;
   logic                       w_acc;
   logic                       w_sel;
   logic                       w_div;
   logic                       w_div0;
   logic                       w_own_rdy;
   logic [DEVIDENT_LENGTH-1:0] w_a;
   logic [DIVISOR_LENGTH-1:0]  w_b;
   logic [DIVISOR_LENGTH-1:0]  w_d;

   // r_rr_ptr=0 favours requester 0 when both are valid
   assign w_idle     = (r_state == IDLE);
   assign w_grant0   = Req0_Valid & (~Req1_Valid | ~r_rr_ptr);
   assign w_grant1   = Req1_Valid & (~Req0_Valid | r_rr_ptr);
   assign Req0_Ready = w_idle & w_grant0;
   assign Req1_Ready = w_idle & w_grant1;
   assign w_acc      = Req0_Ready | Req1_Ready;
   assign w_sel      = w_grant1;
   assign w_div      = w_sel ? Req1_Div_nMul : Req0_Div_nMul;
   assign w_a        = w_sel ? Req1_OperA    : Req0_OperA;
   assign w_b        = w_sel ? Req1_OperB    : Req0_OperB;
   assign w_d        = w_sel ? Req1_OperD    : Req0_OperD;
   assign w_div0     = w_div & (w_d == '0);
   assign w_own_rdy  = r_owner ? Rsp1_Ready : Rsp0_Ready;

   assign Rsp0_Valid    = r_rsp0_vld;
   assign Rsp1_Valid    = r_rsp1_vld;
   assign Rsp_Result    = r_result;
   assign Rsp_Remainder = r_rem;
   assign Rsp_DivByZero = r_dbz;
   assign MD_OperA      = r_md_a;
   assign MD_OperB      = r_md_b;
   assign MD_OperD      = r_md_d;
   assign MD_Div_nMul   = r_md_div;
   assign Busy          = ~w_idle;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_owner    <= 1'b0;
         r_rr_ptr   <= 1'b0;
         r_rsp0_vld <= 1'b0;
         r_rsp1_vld <= 1'b0;
         r_dbz      <= 1'b0;
         r_md_div   <= 1'b0;
         r_result   <= '0;
         r_rem      <= '0;
         r_md_a     <= '0;
         r_md_b     <= '0;
         r_md_d     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_acc) begin
                  r_md_a   <= w_a;
                  r_md_b   <= w_b;
                  r_md_d   <= w_d;
                  r_md_div <= w_div;
                  r_owner  <= w_sel;
                  r_rr_ptr <= ~w_sel;
                  if (w_div0) begin
                     // Datapath output is meaningless for a zero divisor, so skip the settle wait
                     r_result   <= '1;
                     r_rem      <= '0;
                     r_dbz      <= 1'b1;
                     r_rsp0_vld <= ~w_sel;
                     r_rsp1_vld <= w_sel;
                     r_state    <= RESP;
                  end else begin
                     r_cnt   <= LP_SETTLE;
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_result   <= MD_Result;
                  r_rem      <= r_md_div ? MD_Remainder : '0;
                  r_dbz      <= 1'b0;
                  r_rsp0_vld <= ~r_owner;
                  r_rsp1_vld <= r_owner;
                  r_state    <= RESP;
               end
            end
            RESP: begin
               if (w_own_rdy) begin
                  r_rsp0_vld <= 1'b0;
                  r_rsp1_vld <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
